pc_stack_seq: RTL and testbench
===============================

// Module: pc_stack_seq
// PURPOSE
//   Parametrised program counter for the down-sampling processor's instruction fetch.
//   Supports load from C_bus, increment, halt-on-finish, and subroutine call/return
//   through a hardware return-address stack.
//   Drives ins_address to instruction memory; control inputs come from the control-unit FSM.
// PARAMETERS
//   ADDR_W     8   width of ins_address / PC register
//   BUS_W      24  width of C_bus (BUS_W >= ADDR_W)
//   INC_STEP   1   increment applied by inc and used for the return address
//   RESET_ADDR 0   PC value after reset
//   STK_DEPTH  4   return-stack entries (power of two, >= 2)
// PORTS
//   clk          in   1          system clock, all state updates on posedge
//   rst          in   1          synchronous, active-high reset
//   enable       in   1          PC update enable; low = hold everything
//   finish       in   1          end of program; sticky halt
//   load         in   1          PC <= C_bus[ADDR_W-1:0]
//   inc          in   1          PC <= PC + INC_STEP
//   call         in   1          push PC+INC_STEP, then PC <= C_bus[ADDR_W-1:0]
//   ret          in   1          PC <= popped return address
//   C_bus        in   BUS_W      target address source; upper bits ignored
//   ins_address  out  ADDR_W     current PC (registered)
//   halted       out  1          1 while in HALT
//   stack_depth  out  log2(STK_DEPTH)+1  number of valid stack entries
//   stack_ovf    out  1          sticky: call attempted with stack full
//   stack_unf    out  1          sticky: ret attempted with stack empty
// BEHAVIOUR
//   Reset: ins_address=RESET_ADDR; halted=0; stack_depth=0; stack_ovf=stack_unf=0.
//     Reset wins over every other input, including from HALT and mid-call.
//   States:
//     RUN  -> HALT when enable & finish at a posedge. PC is not updated on that edge.
//     HALT -> RUN only via rst. In HALT all inputs are ignored and outputs are frozen.
//   In RUN with enable=0: no state change.
//   In RUN with enable=1 & finish=0, one action per cycle, priority ret > call > load > inc.
//     None asserted: PC holds.
//   Latency: the action takes effect on ins_address at the same posedge (1-cycle registered).
//   Arithmetic: PC+INC_STEP is modulo 2^ADDR_W. The all-ones PC wraps to 0 with no flag.
//   call:
//     stack not full: push PC+INC_STEP, depth+1, PC <= target.
//     stack full: push discarded, stack_ovf <= 1, depth unchanged, jump still taken.
//   ret:
//     stack not empty: PC <= top entry, depth-1.
//     stack empty: stack_unf <= 1, PC <= PC+INC_STEP (falls through).
//   Simultaneous call & ret: ret executes; call is dropped, no push.
//   Flags stay set until rst.
// CONFIGURATION
//   PC_CALL_STACK_EN defined: return stack and call/ret behave as above.
//   PC_CALL_STACK_EN undefined:
//     - no stack storage
//     - call behaves exactly as load
//     - ret ignored (priority falls to call/load/inc)
//     - stack_depth, stack_ovf, stack_unf tied to 0
// TESTING
//   1. rst=1 for 2 cycles, then enable=1, load=1, C_bus=24'h000001 -> ins_address=1 next edge, halted=0.
//   2. inc held 10 cycles from PC=8'hFA -> sequence FB..FF, 00..04; wrap with no flag.
//   3. PC=10, call C_bus=24'hFF0040 -> PC=40, depth=1.
//      Then ret -> PC=11, depth=0. Upper bus bits ignored.
//   4. STK_DEPTH=4: five nested calls -> depth=4, stack_ovf=1, PC=5th target.
//      Then five rets -> 4 pops, then stack_unf=1 with PC+1.
//   5. finish=1 with inc=1 at PC=20 -> halted=1, PC stays 20.
//      load/inc/call ignored afterwards; rst -> PC=RESET_ADDR, halted=0.
//   6. call&ret same cycle with depth=1 (top=33) -> PC=33, depth=0, no push.
//      Repeat with macro undefined: call acts as load, stack outputs stay 0.

Source files
------------

// File: rtl/pc_stack_seq.sv
// Program counter for instruction fetch: load, increment, sticky halt, and call/ret.
// The hardware return-address stack is built only when PC_CALL_STACK_EN is defined.
module pc_stack_seq #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned BUS_W      = 24,
  parameter int unsigned INC_STEP   = 1,
  parameter int unsigned RESET_ADDR = 0,
  parameter int unsigned STK_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           finish,
  input  logic                           load,
  input  logic                           inc,
  input  logic                           call,
  input  logic                           ret,
  input  logic [BUS_W-1:0]               C_bus,
  output logic [ADDR_W-1:0]              ins_address,
  output logic                           halted,
  output logic [$clog2(STK_DEPTH):0]     stack_depth,
  output logic                           stack_ovf,
  output logic                           stack_unf
);

  localparam int unsigned PTR_W   = $clog2(STK_DEPTH);
  localparam int unsigned DEPTH_W = PTR_W + 1;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic [ADDR_W-1:0]   target;
  logic [ADDR_W-1:0]   pc_inc;

  assign target = C_bus[ADDR_W-1:0];
  assign pc_inc = pc_q + ADDR_W'(INC_STEP);

`ifdef PC_CALL_STACK_EN
  logic [ADDR_W-1:0]   stack_q [STK_DEPTH];
  logic [PTR_W-1:0]    top_idx;
  logic [PTR_W-1:0]    push_idx;
  logic                push;
  logic                unused_bus;

  assign top_idx    = PTR_W'(depth_q - DEPTH_W'(1));
  assign push_idx   = PTR_W'(depth_q);
  assign unused_bus = ^C_bus;

  // Return-address storage; push is only raised when depth < STK_DEPTH.
  always_ff @(posedge clk) begin
    if (!rst && push) stack_q[push_idx] <= pc_inc;
  end
`else
  logic unused_in;
  assign unused_in = ^{ret, C_bus};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= ADDR_W'(RESET_ADDR);
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // One action per enabled RUN cycle: finish, then ret > call > load > inc.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
`ifdef PC_CALL_STACK_EN
    push    = 1'b0;
`endif
    if (state_q == RUN && enable) begin
      if (finish) begin
        state_d = HALT;
      end
`ifdef PC_CALL_STACK_EN
      else if (ret) begin
        if (depth_q != '0) begin
          pc_d    = stack_q[top_idx];
          depth_d = depth_q - DEPTH_W'(1);
        end else begin
          unf_d = 1'b1;
          pc_d  = pc_inc;
        end
      end else if (call) begin
        if (depth_q != DEPTH_W'(STK_DEPTH)) begin
          push    = 1'b1;
          depth_d = depth_q + DEPTH_W'(1);
        end else begin
          ovf_d = 1'b1;
        end
        pc_d = target;
      end
`else
      else if (call) begin
        pc_d = target;
      end
`endif
      else if (load) begin
        pc_d = target;
      end else if (inc) begin
        pc_d = pc_inc;
      end
    end
  end

  assign ins_address = pc_q;
  assign halted      = (state_q == HALT);
  assign stack_depth = depth_q;
  assign stack_ovf   = ovf_q;
  assign stack_unf   = unf_q;

endmodule

// File: tb/tb_pc_stack_seq.sv
// Directed vector bench for pc_stack_seq; expectations follow PC_CALL_STACK_EN if defined.
module tb_pc_stack_seq;

  logic        clk = 1'b0;
  logic        rst, enable, finish, load, inc, call, ret;
  logic [23:0] C_bus;
  logic [7:0]  ins_address;
  logic        halted;
  logic [2:0]  stack_depth;
  logic        stack_ovf, stack_unf;

  int errors = 0;
  int checks = 0;

  pc_stack_seq dut (
    .clk(clk), .rst(rst), .enable(enable), .finish(finish), .load(load),
    .inc(inc), .call(call), .ret(ret), .C_bus(C_bus),
    .ins_address(ins_address), .halted(halted), .stack_depth(stack_depth),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, en, fin, ld, in, ca, re;
    logic [23:0] bus;
    logic [7:0]  pc;
    logic        hlt;
    logic [2:0]  dep;
    logic        ovf, unf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic e, input logic f, input logic l,
                              input logic i, input logic c, input logic t, input logic [23:0] b,
                              input logic [7:0] pc, input logic h, input logic [2:0] d,
                              input logic o, input logic u);
    vec_t v;
    v.rst = r; v.en = e; v.fin = f; v.ld = l; v.in = i; v.ca = c; v.re = t; v.bus = b;
    v.pc = pc; v.hlt = h; v.dep = d; v.ovf = o; v.unf = u;
    vecs.push_back(v);
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst; enable = v.en; finish = v.fin; load = v.ld; inc = v.in;
    call = v.ca; ret = v.re; C_bus = v.bus;
  endtask

  task automatic check(input string name, input vec_t v);
    checks++;
    if (ins_address !== v.pc || halted !== v.hlt || stack_depth !== v.dep ||
        stack_ovf !== v.ovf || stack_unf !== v.unf) begin
      errors++;
      $display("FAIL %s: got pc=%h halted=%b depth=%0d ovf=%b unf=%b, want pc=%h halted=%b depth=%0d ovf=%b unf=%b",
               name, ins_address, halted, stack_depth, stack_ovf, stack_unf,
               v.pc, v.hlt, v.dep, v.ovf, v.unf);
    end
  endtask

  initial begin
    vec_t v;
    logic [7:0] p;
    drive('{default: '0});

    //   rst en fin ld in ca re bus          pc     h  dep ov un
    add(1, 0, 0, 0, 0, 0, 0, 24'h0,       8'h00, 0, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0, 0, 24'h000099,  8'h00, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0, 24'h000001,  8'h01, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0, 24'h0000FA,  8'hFA, 0, 0, 0, 0);
    p = 8'hFA;
    for (int k = 0; k < 10; k++) begin
      p = p + 8'd1;
      add(0, 1, 0, 0, 1, 0, 0, 24'h0, p, 0, 0, 0, 0);
    end
    add(0, 1, 0, 0, 0, 0, 0, 24'h0,       8'h04, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0, 24'hAB0010,  8'h10, 0, 0, 0, 0);
`ifdef PC_CALL_STACK_EN
    add(0, 1, 0, 0, 0, 1, 0, 24'hFF0040,  8'h40, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 24'h0,       8'h11, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 24'h000001,  8'h01, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 24'h000002,  8'h02, 0, 2, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 24'h000003,  8'h03, 0, 3, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 24'h000004,  8'h04, 0, 4, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 24'h000005,  8'h05, 0, 4, 1, 0);
    add(0, 1, 0, 0, 0, 0, 1, 24'h0,       8'h04, 0, 3, 1, 0);
    add(0, 1, 0, 0, 0, 0, 1, 24'h0,       8'h03, 0, 2, 1, 0);
    add(0, 1, 0, 0, 0, 0, 1, 24'h0,       8'h02, 0, 1, 1, 0);
    add(0, 1, 0, 0, 0, 0, 1, 24'h0,       8'h12, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 1, 24'h0,       8'h13, 0, 0, 1, 1);
    add(0, 1, 0, 1, 0, 0, 0, 24'h000032,  8'h32, 0, 0, 1, 1);
    add(0, 1, 0, 0, 0, 1, 0, 24'h000070,  8'h70, 0, 1, 1, 1);
    add(0, 1, 0, 1, 1, 1, 1, 24'h000050,  8'h33, 0, 0, 1, 1);
    add(0, 0, 0, 1, 1, 1, 0, 24'h000060,  8'h33, 0, 0, 1, 1);
    add(0, 1, 0, 1, 0, 0, 0, 24'h000020,  8'h20, 0, 0, 1, 1);
    add(0, 1, 1, 0, 1, 0, 0, 24'h0,       8'h20, 1, 0, 1, 1);
    add(0, 1, 0, 1, 0, 0, 0, 24'h000005,  8'h20, 1, 0, 1, 1);
    add(0, 1, 0, 0, 0, 1, 0, 24'h000006,  8'h20, 1, 0, 1, 1);
    add(0, 1, 0, 0, 1, 0, 1, 24'h0,       8'h20, 1, 0, 1, 1);
`else
    add(0, 1, 0, 0, 0, 1, 0, 24'hFF0040,  8'h40, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 24'h000077,  8'h40, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0, 1, 24'h0,       8'h41, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 1, 1, 24'h000033,  8'h33, 0, 0, 0, 0);
    add(0, 1, 0, 1, 1, 1, 0, 24'h000055,  8'h55, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 1, 0, 24'h000060,  8'h55, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0, 24'h000020,  8'h20, 0, 0, 0, 0);
    add(0, 1, 1, 0, 1, 0, 0, 24'h0,       8'h20, 1, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0, 24'h000005,  8'h20, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 24'h000006,  8'h20, 1, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0, 1, 24'h0,       8'h20, 1, 0, 0, 0);
`endif
    add(1, 1, 0, 1, 1, 0, 0, 24'h000044,  8'h00, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0, 0, 24'h0,       8'h01, 0, 0, 0, 0);

    foreach (vecs[k]) begin
      drive(vecs[k]);
      @(posedge clk); #1;
      check($sformatf("vec%0d", k), vecs[k]);
    end

    // Halt is sticky: several cycles of every control asserted must not move anything.
    drive('{default: '0});
    enable = 1'b1; load = 1'b1; C_bus = 24'h000088;
    @(posedge clk); #1;
    v = '{default: '0}; v.pc = 8'h88;
    check("pre_halt_load", v);
    finish = 1'b1; load = 1'b0; inc = 1'b1;
    @(posedge clk); #1;
    v.hlt = 1'b1;
    check("halt_entry", v);
    finish = 1'b0;
    for (int k = 0; k < 4; k++) begin
      load = k[0]; inc = 1'b1; call = k[1]; ret = ~k[0]; C_bus = 24'(k * 16 + 3);
      @(posedge clk); #1;
      check($sformatf("halt_freeze%0d", k), v);
    end

    // Reset wins even while a call is requested.
    drive('{default: '0});
    rst = 1'b1; enable = 1'b1; call = 1'b1; C_bus = 24'h000077;
    @(posedge clk); #1;
    v = '{default: '0};
    check("rst_over_call", v);
    rst = 1'b0; call = 1'b0; enable = 1'b1; inc = 1'b1;
    @(posedge clk); #1;
    v.pc = 8'h01;
    check("post_rst_inc", v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
